// File: rtl/boton_arbiter.sv
// Classifies debounced button presses as short or long, queues one pending event
// per button and kind, and presents them one at a time with a post-ack lockout.
module boton_arbiter #(
    parameter int N_BTN     = 4,
    parameter int LONG_TIME = 25_000_000,
    parameter int LOCKOUT   = 50_000,
    localparam int ID_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             evt_ack,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    output logic             overrun
);

    localparam int CNT_W = $clog2(LONG_TIME + 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_TIME);
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_TIME - 1);
    localparam int LK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, PRESENT, LOCK} state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] hold_cnt_reg  [N_BTN];
    logic [CNT_W-1:0] hold_cnt_next [N_BTN];
    logic [N_BTN-1:0] pend_long_reg, pend_long_next;
    logic [N_BTN-1:0] pend_short_reg, pend_short_next;
    logic [N_BTN-1:0] new_long, new_short;
    logic [N_BTN-1:0] clr_long, clr_short;
    logic [N_BTN-1:0] drop_long, drop_short;
    logic [LK_W-1:0]  lock_cnt_reg;
    logic [ID_W-1:0]  evt_id_reg;
    logic             evt_long_reg;
    logic             overrun_reg;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic             win_long;
    logic             load;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            // The counter saturates, so the long event can only fire once per press.
            assign new_long[gi]  = btn_in[gi] && (hold_cnt_reg[gi] == LONG_PRE);
            assign new_short[gi] = !btn_in[gi] && (hold_cnt_reg[gi] != '0)
                                   && (hold_cnt_reg[gi] != LONG_MAX);
            assign hold_cnt_next[gi] = !btn_in[gi] ? '0 :
                                       (hold_cnt_reg[gi] == LONG_MAX) ? LONG_MAX :
                                       hold_cnt_reg[gi] + CNT_W'(1);

            // A bit being handed to the FSM this cycle counts as free again.
            assign drop_long[gi]       = new_long[gi] && pend_long_reg[gi] && !clr_long[gi];
            assign drop_short[gi]      = new_short[gi] && pend_short_reg[gi] && !clr_short[gi];
            assign pend_long_next[gi]  = (pend_long_reg[gi] && !clr_long[gi]) || new_long[gi];
            assign pend_short_next[gi] = (pend_short_reg[gi] && !clr_short[gi]) || new_short[gi];
        end
    endgenerate

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_long  = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_long_reg[i] || pend_short_reg[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_long  = pend_long_reg[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        clr_long   = '0;
        clr_short  = '0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    load       = 1'b1;
                    state_next = PRESENT;
                    if (win_long) begin
                        clr_long[win_id] = 1'b1;
                    end else begin
                        clr_short[win_id] = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (evt_ack) begin
                    state_next = (LOCKOUT == 0) ? IDLE : LOCK;
                end
            end
            LOCK: begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pend_long_reg  <= '0;
            pend_short_reg <= '0;
            lock_cnt_reg   <= '0;
            evt_id_reg     <= '0;
            evt_long_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                hold_cnt_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            pend_long_reg  <= pend_long_next;
            pend_short_reg <= pend_short_next;
            overrun_reg    <= overrun_reg || (|drop_long) || (|drop_short);
            for (int i = 0; i < N_BTN; i++) begin
                hold_cnt_reg[i] <= hold_cnt_next[i];
            end
            if (state_reg == LOCK) begin
                lock_cnt_reg <= lock_cnt_reg + LK_W'(1);
            end else begin
                lock_cnt_reg <= '0;
            end
            if (load) begin
                evt_id_reg   <= win_id;
                evt_long_reg <= win_long;
            end
        end
    end

    assign evt_valid = (state_reg == PRESENT);
    assign evt_id    = evt_id_reg;
    assign evt_long  = evt_long_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_boton_arbiter.sv
// Directed bench for boton_arbiter with N_BTN=4, LONG_TIME=8, LOCKOUT=2: a per-cycle
// vector table for the main scenarios plus hand-written reset and stray-ack sequences.
module tb_boton_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = '0;
    logic       evt_ack = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    boton_arbiter #(
        .N_BTN    (4),
        .LONG_TIME(8),
        .LOCKOUT  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .evt_ack  (evt_ack),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_long (evt_long),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       ack;
        logic       rst;
        logic       v;
        logic [1:0] id;
        logic       lg;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    // Append n identical cycles: inputs sampled at the edge, outputs expected after it.
    function automatic void add(input logic [3:0] b, input logic a, input logic r,
                                input logic v, input logic [1:0] id, input logic lg,
                                input logic ov, input int n);
        vec_t e;
        e.btn = b; e.ack = a; e.rst = r; e.v = v; e.id = id; e.lg = lg; e.ov = ov;
        for (int k = 0; k < n; k++) vecs.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;

        // reset
        add(4'h0, 0, 1, 0, 0, 0, 0, 2);
        // btn1 short press, ack one cycle after valid, lockout gap
        add(4'h2, 0, 0, 0, 0, 0, 0, 3);
        add(4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 0, 0, 2);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 3);
        // btn2 held 12 cycles: long event after the 8th held edge, silent release
        add(4'h4, 0, 0, 0, 0, 0, 0, 8);
        add(4'h4, 0, 0, 1, 2, 1, 0, 4);
        add(4'h0, 0, 0, 1, 2, 1, 0, 1);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 4);
        // btn0 and btn3 released together; btn0 held un-acked 5 cycles, then btn3
        add(4'h9, 0, 0, 0, 0, 0, 0, 2);
        add(4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 1, 0, 0, 0, 5);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(4'h0, 0, 0, 1, 3, 0, 0, 1);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 3);
        // btn1 long and short both pending behind btn0: long served first
        add(4'h1, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 1, 0, 0, 0, 1);
        add(4'h2, 0, 0, 1, 0, 0, 0, 8);
        add(4'h0, 0, 0, 1, 0, 0, 0, 1);
        add(4'h2, 0, 0, 1, 0, 0, 0, 2);
        add(4'h0, 0, 0, 1, 0, 0, 0, 1);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(4'h0, 0, 0, 1, 1, 1, 0, 1);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(4'h0, 0, 0, 1, 1, 0, 0, 1);
        add(4'h0, 1, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 3);
        // two more btn1 presses while btn1 is presented: second one overruns
        add(4'h2, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 0, 0, 1);
        add(4'h2, 0, 0, 1, 1, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 0, 0, 1);
        add(4'h2, 0, 0, 1, 1, 0, 0, 1);
        add(4'h0, 0, 0, 1, 1, 0, 1, 1);
        add(4'h0, 1, 0, 0, 0, 0, 1, 1);
        add(4'h0, 0, 0, 0, 0, 0, 1, 2);
        add(4'h0, 0, 0, 1, 1, 0, 1, 1);
        add(4'h0, 1, 0, 0, 0, 0, 1, 1);
        add(4'h0, 0, 0, 0, 0, 0, 1, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            btn_in  = vecs[i].btn;
            evt_ack = vecs[i].ack;
            tick();
            $display("row %0d rst=%b btn=%b ack=%b -> valid=%b id=%0d long=%b ovr=%b",
                     i, vecs[i].rst, vecs[i].btn, vecs[i].ack,
                     evt_valid, evt_id, evt_long, overrun);
            check($sformatf("row%0d valid", i), int'(evt_valid), int'(vecs[i].v));
            check($sformatf("row%0d overrun", i), int'(overrun), int'(vecs[i].ov));
            if (vecs[i].v || vecs[i].rst) begin
                check($sformatf("row%0d id", i), int'(evt_id), int'(vecs[i].id));
                check($sformatf("row%0d long", i), int'(evt_long), int'(vecs[i].lg));
            end
        end
        rst = 1'b0; btn_in = '0; evt_ack = 1'b0;

        // reset while presenting btn0 with btn2 still pending
        btn_in = 4'h5;
        tick(); tick();
        btn_in = 4'h0;
        tick(); tick();
        $display("seq rst_present: valid=%b id=%0d ovr=%b", evt_valid, evt_id, overrun);
        check("pre_rst valid", int'(evt_valid), 1);
        check("pre_rst id", int'(evt_id), 0);
        check("pre_rst overrun", int'(overrun), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("seq rst_applied: valid=%b id=%0d long=%b ovr=%b",
                 evt_valid, evt_id, evt_long, overrun);
        check("rst valid", int'(evt_valid), 0);
        check("rst id", int'(evt_id), 0);
        check("rst long", int'(evt_long), 0);
        check("rst overrun", int'(overrun), 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("post_rst valid c%0d", k), int'(evt_valid), 0);
        end
        $display("seq post_rst: quiet window done");

        // stray acks while idle, one coinciding with the release edge
        evt_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("idle_ack valid c%0d", k), int'(evt_valid), 0);
        end
        evt_ack = 1'b0;
        btn_in  = 4'h4;
        tick(); tick();
        btn_in  = 4'h0;
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        waited = 0;
        while (!evt_valid && waited < 10) begin
            tick();
            waited++;
        end
        $display("seq stray_ack: valid=%b id=%0d long=%b after %0d cycles",
                 evt_valid, evt_id, evt_long, waited);
        check("stray_ack valid", int'(evt_valid), 1);
        check("stray_ack latency", waited, 1);
        check("stray_ack id", int'(evt_id), 2);
        check("stray_ack long", int'(evt_long), 0);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        check("stray_ack acked", int'(evt_valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stray_ack quiet c%0d", k), int'(evt_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
